ps2_key_cmd_decoder: RTL and testbench



---
 rtl/ps2_key_cmd_decoder.sv | 106 ++++++++++
 tb/tb_ps2_key_cmd_decoder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_cmd_decoder.sv
// Maps decoded PS/2 key events onto NCH command channels.
// Each channel runs in pulse-on-release, toggle, level or pulse-on-make mode.
module ps2_key_cmd_decoder #(
  parameter int               NCH       = 4,
  parameter logic [NCH*8-1:0] KEYS_A    = {8'h25, 8'h26, 8'h1E, 8'h16},
  parameter logic [NCH*8-1:0] KEYS_B    = {8'h6B, 8'h7A, 8'h72, 8'h69},
  parameter logic [NCH-1:0]   EXT_A     = '0,
  parameter logic [NCH*2-1:0] MODE      = {2'b11, 2'b10, 2'b01, 2'b00},
  parameter int               PULSE_LEN = 4,
  parameter logic [NCH-1:0]   INIT      = '0,
  localparam int              CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_event,
  input  logic [7:0]      scancode,
  input  logic            released,
  input  logic            extended,
  input  logic            clear,
  output logic [NCH-1:0]  cmd_out,
  output logic [NCH-1:0]  held,
  output logic            match_valid,
  output logic [CH_W-1:0] match_ch
);

  localparam int              CNT_W = $clog2(PULSE_LEN + 1);
  localparam logic [CNT_W-1:0] PLEN = CNT_W'(PULSE_LEN);

  // An event that arrives together with clear is discarded entirely.
  logic            accept;
  logic [NCH-1:0]  hit;
  logic [NCH-1:0]  make_hit;
  logic [NCH-1:0]  brk_hit;
  logic [CH_W-1:0] first_ch;

  assign accept = key_event & ~clear;

  for (genvar i = 0; i < NCH; i++) begin : g_match
    logic prim;
    logic alt;
    assign prim        = (scancode == KEYS_A[8*i +: 8]) && (extended == EXT_A[i]);
    assign alt         = (KEYS_B[8*i +: 8] != 8'h00) && (scancode == KEYS_B[8*i +: 8]) && !extended;
    assign hit[i]      = accept & (prim | alt);
    assign make_hit[i] = hit[i] & ~released;
    assign brk_hit[i]  = hit[i] & released;
  end

  always_comb begin
    first_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hit[i]) first_ch = CH_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_valid <= 1'b0;
      match_ch    <= '0;
    end else begin
      match_valid <= |hit;
      if (|hit) match_ch <= first_ch;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [1:0] M = MODE[2*i +: 2];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           held[i] <= 1'b0;
      else if (clear)       held[i] <= 1'b0;
      else if (make_hit[i]) held[i] <= 1'b1;
      else if (brk_hit[i])  held[i] <= 1'b0;
    end

    if (M == 2'b00 || M == 2'b11) begin : g_pulse
      logic [CNT_W-1:0] cnt;
      logic             load;
      // Repeated makes and stray breaks are filtered by the key-down state.
      if (M == 2'b00) begin : g_rel
        assign load = brk_hit[i] & held[i];
      end else begin : g_make
        assign load = make_hit[i] & ~held[i];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            cnt <= '0;
        else if (clear)        cnt <= '0;
        else if (load)         cnt <= PLEN;
        else if (cnt != '0)    cnt <= cnt - 1'b1;
      end

      assign cmd_out[i] = (cnt != '0);
    end else if (M == 2'b01) begin : g_toggle
      logic tog;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     tog <= INIT[i];
        else if (clear)                 tog <= INIT[i];
        else if (brk_hit[i] && held[i]) tog <= ~tog;
      end
      assign cmd_out[i] = tog;
    end else begin : g_level
      assign cmd_out[i] = held[i];
    end
  end

endmodule

// File: tb/tb_ps2_key_cmd_decoder.sv
// Directed and randomized bench for ps2_key_cmd_decoder with an event-level reference model.
module tb_ps2_key_cmd_decoder;

  localparam int         PL    = 4;
  localparam logic [3:0] INITV = 4'b0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_event = 1'b0;
  logic [7:0] scancode = 8'h00;
  logic       released = 1'b0;
  logic       extended = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] cmd_out;
  logic [3:0] held;
  logic       match_valid;
  logic [1:0] match_ch;

  ps2_key_cmd_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_event   (key_event),
    .scancode    (scancode),
    .released    (released),
    .extended    (extended),
    .clear       (clear),
    .cmd_out     (cmd_out),
    .held        (held),
    .match_valid (match_valid),
    .match_ch    (match_ch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: channel bindings and per-channel behaviour in event terms.
  logic [7:0] ka [4] = '{8'h16, 8'h1E, 8'h26, 8'h25};
  logic [7:0] kb [4] = '{8'h69, 8'h72, 8'h7A, 8'h6B};
  int         md [4] = '{0, 1, 2, 3};
  int         cyc;
  bit         m_held [4];
  int         m_end  [4];
  bit         m_tog  [4];
  bit         m_mv;
  int         m_mch;

  function automatic logic [3:0] exp_cmd();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      case (md[i])
        1:       r[i] = m_tog[i];
        2:       r[i] = m_held[i];
        default: r[i] = (cyc <= m_end[i]);
      endcase
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_held();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_held[i];
    return r;
  endfunction

  function automatic logic [10:0] exp_all();
    return {exp_cmd(), exp_held(), m_mv, 2'(m_mch)};
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      m_held[i] = 1'b0;
      m_end[i]  = -1;
      m_tog[i]  = INITV[i];
    end
    m_mv  = 1'b0;
    m_mch = 0;
  endtask

  task automatic model_edge(input bit ev, input logic [7:0] sc, input bit rel, input bit ext, input bit clr);
    int lowest;
    bit hit;
    cyc++;
    m_mv = 1'b0;
    if (clr) begin
      for (int i = 0; i < 4; i++) begin
        m_held[i] = 1'b0;
        m_end[i]  = -1;
        m_tog[i]  = INITV[i];
      end
      return;
    end
    if (!ev) return;
    lowest = -1;
    for (int i = 0; i < 4; i++) begin
      hit = (sc == ka[i] && !ext) || (kb[i] != 8'h00 && sc == kb[i] && !ext);
      if (!hit) continue;
      m_mv = 1'b1;
      if (lowest < 0) lowest = i;
      if (!rel) begin
        if (!m_held[i] && md[i] == 3) m_end[i] = cyc + PL - 1;
        m_held[i] = 1'b1;
      end else begin
        if (m_held[i] && md[i] == 0) m_end[i] = cyc + PL - 1;
        if (m_held[i] && md[i] == 1) m_tog[i] = ~m_tog[i];
        m_held[i] = 1'b0;
      end
    end
    if (lowest >= 0) m_mch = lowest;
  endtask

  task automatic step(input bit ev, input logic [7:0] sc, input bit rel, input bit ext, input bit clr);
    key_event = ev;
    scancode  = sc;
    released  = rel;
    extended  = ext;
    clear     = clr;
    @(posedge clk);
    model_edge(ev, sc, rel, ext, clr);
    #1;
    key_event = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({cmd_out, held, match_valid, match_ch} !== {INITV, 4'b0000, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", {cmd_out, held, match_valid, match_ch}, {INITV, 4'b0000, 1'b0, 2'd0});
    end
  endtask

  task automatic test_pulse_release();
    int highs;
    step(1, 8'h16, 0, 0, 0);
    repeat (3) step(0, 8'h00, 0, 0, 0);
    step(1, 8'h16, 1, 0, 0);
    checks++;
    if ({match_valid, match_ch} !== {1'b1, 2'd0}) begin
      failures++;
      $display("FAIL release_match got=%b/%0d exp=1/0", match_valid, match_ch);
    end
    highs = 0;
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (cmd_out[0] !== (k <= PL)) begin
        failures++;
        $display("FAIL release_pulse k=%0d got=%b exp=%b", k, cmd_out[0], (k <= PL));
      end
      checks++;
      if ({cmd_out, held, match_valid, match_ch} !== exp_all()) begin
        failures++;
        $display("FAIL release_model k=%0d got=%h exp=%h", k, {cmd_out, held, match_valid, match_ch}, exp_all());
      end
      step(0, 8'h00, 0, 0, 0);
    end
  endtask

  task automatic test_toggle();
    logic [7:0] codes [2] = '{8'h1E, 8'h72};
    logic       want  [2] = '{1'b1, 1'b0};
    for (int j = 0; j < 2; j++) begin
      step(1, codes[j], 0, 0, 0);
      step(0, 8'h00, 0, 0, 0);
      checks++;
      if (cmd_out[1] !== ~want[j]) begin
        failures++;
        $display("FAIL toggle_before j=%0d got=%b exp=%b", j, cmd_out[1], ~want[j]);
      end
      step(1, codes[j], 1, 0, 0);
      checks++;
      if (cmd_out[1] !== want[j] || match_ch !== 2'd1) begin
        failures++;
        $display("FAIL toggle_after j=%0d got=%b/%0d exp=%b/1", j, cmd_out[1], match_ch, want[j]);
      end
    end
  endtask

  task automatic test_level();
    step(1, 8'h26, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if ({cmd_out[2], held[2]} !== 2'b11) begin
        failures++;
        $display("FAIL level_held r=%0d got=%b exp=11", r, {cmd_out[2], held[2]});
      end
      step(0, 8'h00, 0, 0, 0);
      checks++;
      if ({cmd_out[2], held[2]} !== 2'b11) begin
        failures++;
        $display("FAIL level_gap r=%0d got=%b exp=11", r, {cmd_out[2], held[2]});
      end
      if (r < 3) step(1, 8'h26, 0, 0, 0);
    end
    step(1, 8'h26, 1, 0, 0);
    checks++;
    if ({cmd_out[2], held[2]} !== 2'b00) begin
      failures++;
      $display("FAIL level_release got=%b exp=00", {cmd_out[2], held[2]});
    end
  endtask

  task automatic test_pulse_make();
    int highs;
    highs = 0;
    step(1, 8'h25, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      highs += cmd_out[3];
      checks++;
      if ({cmd_out, held, match_valid, match_ch} !== exp_all()) begin
        failures++;
        $display("FAIL make_model k=%0d got=%h exp=%h", k, {cmd_out, held, match_valid, match_ch}, exp_all());
      end
      if (k == 1 || k == 3) step(1, 8'h25, 0, 0, 0);
      else step(0, 8'h00, 0, 0, 0);
    end
    checks++;
    if (highs != PL) begin
      failures++;
      $display("FAIL make_repeat_width got=%0d exp=%0d", highs, PL);
    end
    step(1, 8'h6B, 1, 0, 0);
    step(1, 8'h6B, 0, 0, 0);
    highs = 0;
    for (int k = 0; k < 8; k++) begin
      highs += cmd_out[3];
      step(0, 8'h00, 0, 0, 0);
    end
    checks++;
    if (highs != PL) begin
      failures++;
      $display("FAIL make_alt_width got=%0d exp=%0d", highs, PL);
    end
  endtask

  task automatic test_stray_break();
    do_reset();
    step(1, 8'h16, 1, 0, 0);
    checks++;
    if ({cmd_out, held, match_valid, match_ch} !== {4'b0000, 4'b0000, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL stray_break got=%h exp=%h", {cmd_out, held, match_valid, match_ch}, {4'b0000, 4'b0000, 1'b1, 2'd0});
    end
    for (int k = 0; k < 5; k++) begin
      step(0, 8'h00, 0, 0, 0);
      checks++;
      if (cmd_out[0] !== 1'b0) begin
        failures++;
        $display("FAIL stray_quiet k=%0d got=%b exp=0", k, cmd_out[0]);
      end
    end
  endtask

  task automatic test_clear();
    step(1, 8'h1E, 0, 0, 0);
    step(1, 8'h1E, 1, 0, 0);
    step(1, 8'h26, 0, 0, 0);
    step(1, 8'h1E, 0, 0, 0);
    checks++;
    if ({cmd_out[1], held[2], held[1]} !== 3'b111) begin
      failures++;
      $display("FAIL clear_setup got=%b exp=111", {cmd_out[1], held[2], held[1]});
    end
    step(1, 8'h1E, 1, 0, 1);
    checks++;
    if ({cmd_out, held, match_valid} !== {INITV, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL clear got=%h exp=%h", {cmd_out, held, match_valid}, {INITV, 4'b0000, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    step(1, 8'h16, 0, 0, 0);
    step(1, 8'h16, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    checks++;
    if (cmd_out[0] !== 1'b1) begin
      failures++;
      $display("FAIL async_pre got=%b exp=1", cmd_out[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_out, held, match_valid} !== {INITV, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", {cmd_out, held, match_valid}, {INITV, 4'b0000, 1'b0});
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] pool [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h00};
    logic [7:0] sc;
    bit         ev, rel, ext, clr;
    for (int n = 0; n < 600; n++) begin
      ev  = ($urandom_range(3, 0) != 0);
      sc  = pool[$urandom_range(8, 0)];
      if (sc == 8'h00) sc = 8'($urandom);
      rel = $urandom_range(1, 0);
      ext = ($urandom_range(7, 0) == 0);
      clr = ($urandom_range(39, 0) == 0);
      step(ev, sc, rel, ext, clr);
      checks++;
      if ({cmd_out, held, match_valid, match_ch} !== exp_all()) begin
        failures++;
        $display("FAIL random n=%0d got=%h exp=%h", n, {cmd_out, held, match_valid, match_ch}, exp_all());
      end
    end
  endtask

  initial begin
    test_reset();
    test_pulse_release();
    test_toggle();
    test_level();
    test_pulse_make();
    test_stray_break();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
